ring_freq_counter: RTL

RING_FREQ_COUNTER -- requirements
Module: ring_freq_counter

---
 rtl/ring_freq_counter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ring_freq_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ring_freq_counter: gated rising-edge counter for an on-chip ring          |
// | oscillator. Optional macro RING_FREQ_OVF_EN: saturate + overflow flag.    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module ring_freq_counter #(
  parameter int CNT_W      = 16,
  parameter int GATE_W     = 16,
  parameter int SETTLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              ring_in,
  output logic              ring_en0,
  output logic              ring_en1,
  output logic [CNT_W-1:0]  count,
  output logic              count_valid,
  input  logic              count_ready,
  output logic              busy
`ifdef RING_FREQ_OVF_EN
  ,
  output logic              overflow
`endif
);

  localparam int SET_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam logic [SET_W-1:0] SETTLE_LD = SET_W'(SETTLE_CYC);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GATE   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state;
  logic               sync1, sync2, sync3;
  logic [SET_W-1:0]   settle_cnt;
  logic [GATE_W-1:0]  gate_cnt;
  logic [CNT_W-1:0]   edge_cnt;
  logic [CNT_W-1:0]   edge_next;
  logic               rise;

  assign rise = sync2 & ~sync3;

`ifdef RING_FREQ_OVF_EN
  logic sat;
  logic sat_hit;

  // An edge arriving while the counter is already all-ones is the saturation event.
  always_comb begin
    edge_next = edge_cnt;
    sat_hit   = 1'b0;
    if (rise) begin
      if (&edge_cnt) begin
        sat_hit = 1'b1;
      end else begin
        edge_next = edge_cnt + CNT_W'(1);
      end
    end
  end
`else
  always_comb begin
    edge_next = edge_cnt + CNT_W'(rise);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      sync3       <= 1'b0;
      settle_cnt  <= '0;
      gate_cnt    <= '0;
      edge_cnt    <= '0;
      count       <= '0;
      count_valid <= 1'b0;
      busy        <= 1'b0;
      ring_en0    <= 1'b0;
      ring_en1    <= 1'b0;
`ifdef RING_FREQ_OVF_EN
      sat         <= 1'b0;
      overflow    <= 1'b0;
`endif
    end else begin
      sync1 <= ring_in;
      sync2 <= sync1;
      sync3 <= sync2;
      case (state)
        IDLE: begin
          if (start) begin
            gate_cnt   <= (gate_len == '0) ? GATE_W'(1) : gate_len;
            settle_cnt <= SETTLE_LD;
            edge_cnt   <= '0;
            busy       <= 1'b1;
            ring_en0   <= 1'b1;
            ring_en1   <= 1'b1;
`ifdef RING_FREQ_OVF_EN
            sat        <= 1'b0;
`endif
            state      <= (SETTLE_CYC == 0) ? GATE : SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt <= SET_W'(1)) begin
            state <= GATE;
          end else begin
            settle_cnt <= settle_cnt - SET_W'(1);
          end
        end
        GATE: begin
          edge_cnt <= edge_next;
`ifdef RING_FREQ_OVF_EN
          sat      <= sat | sat_hit;
`endif
          // The edge seen in the closing gate cycle is folded into the result.
          if (gate_cnt <= GATE_W'(1)) begin
            state       <= DONE;
            count       <= edge_next;
            count_valid <= 1'b1;
            ring_en0    <= 1'b0;
            ring_en1    <= 1'b0;
`ifdef RING_FREQ_OVF_EN
            overflow    <= sat | sat_hit;
`endif
          end else begin
            gate_cnt <= gate_cnt - GATE_W'(1);
          end
        end
        DONE: begin
          if (count_valid && count_ready) begin
            state       <= IDLE;
            count_valid <= 1'b0;
            busy        <= 1'b0;
`ifdef RING_FREQ_OVF_EN
            overflow    <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
